// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and any future bus monitor.
// Holds the FSM state encoding, ACK/NACK levels and the default frame width.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int DEFAULT_FRAME_BITS = 8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection.
// Both lines reset to the idle-high level so a reset never fakes a bus condition.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_o = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise_o  = scl_s & ~scl_hist_q;
    assign scl_fall_o  = ~scl_s & scl_hist_q;
    // SDA may only move while SCL is high for a START or STOP.
    assign start_det_o = scl_s & scl_hist_q & sda_hist_q & ~sda_o;
    assign stop_det_o  = scl_s & scl_hist_q & ~sda_hist_q & sda_o;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: fixed-address match, write bytes to rx_data, read bytes from tx_data.
// SDA is open-drain; SCL is never stretched.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_match,
    output logic       rw_latched,
    output logic       nack_rx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT   = 3'(FRAME_BITS - 1);
    localparam logic [7:0] FRAME_MASK = 8'((16'd1 << FRAME_BITS) - 16'd1);

    logic   sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic   [7:0] frame_in;
    logic   addr_hit;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       ack_phase_q, ack_phase_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_match_q, addr_match_d;
    logic       nack_rx_q, nack_rx_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl),
        .sda_i       (sda),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign frame_in = {shift_q, sda_s} & FRAME_MASK;
    assign addr_hit = (frame_in[FRAME_BITS-1:1] == SLAVE_ADDR[FRAME_BITS-2:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_shift_q   <= '0;
            sda_oe_q     <= 1'b0;
            ack_phase_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;
            nack_rx_q    <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_shift_q   <= tx_shift_d;
            sda_oe_q     <= sda_oe_d;
            ack_phase_q  <= ack_phase_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            addr_match_q <= addr_match_d;
            nack_rx_q    <= nack_rx_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_shift_d   = tx_shift_q;
        sda_oe_d     = sda_oe_q;
        ack_phase_d  = ack_phase_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        addr_match_d = 1'b0;
        nack_rx_d    = 1'b0;
        rw_d         = rw_q;
        busy_d       = busy_q;

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d = frame_in[6:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (addr_hit) begin
                            addr_match_d = 1'b1;
                            tx_req_d     = sda_s;
                            rw_d         = sda_s;
                            busy_d       = 1'b1;
                            ack_phase_d  = 1'b0;
                            state_d      = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            // ACK slots: first SCL fall pulls SDA low, second fall ends the slot.
            ST_ADDR_ACK, ST_RX_ACK: begin
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_oe_d    = 1'b1;
                        ack_phase_d = 1'b1;
                    end else begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = '0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            tx_shift_d = tx_data;
                            sda_oe_d   = ~tx_data[FRAME_BITS-1];
                            state_d    = ST_TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX;
                        end
                    end
                end
            end
            ST_RX: begin
                if (scl_rise) begin
                    shift_d = frame_in[6:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d   = frame_in;
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = '0;
                        ack_phase_d = 1'b0;
                        state_d     = ST_RX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_TX: begin
                if (scl_fall) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        sda_oe_d    = 1'b0;
                        bit_cnt_d   = '0;
                        ack_phase_d = 1'b0;
                        state_d     = ST_TX_ACK;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        sda_oe_d   = ~tx_shift_q[FRAME_BITS-2];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            // ack_phase_q marks that the master ACKed and a reload is pending.
            ST_TX_ACK: begin
                if (scl_rise && !ack_phase_q) begin
                    if (sda_s == ACK) begin
                        tx_req_d    = 1'b1;
                        ack_phase_d = 1'b1;
                    end else begin
                        nack_rx_d = 1'b1;
                        state_d   = ST_WAIT_STOP;
                    end
                end else if (scl_fall && ack_phase_q) begin
                    tx_shift_d  = tx_data;
                    sda_oe_d    = ~tx_data[FRAME_BITS-1];
                    bit_cnt_d   = '0;
                    ack_phase_d = 1'b0;
                    state_d     = ST_TX;
                end
            end
            ST_IDLE, ST_WAIT_STOP: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            busy_d      = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = tx_req_q;
    assign addr_match = addr_match_q;
    assign rw_latched = rw_q;
    assign nack_rx    = nack_rx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C master model drives two targets,
// an 8-bit-frame one on bus A and a 4-bit-frame one on bus B.
module tb_i2c_target;

    localparam int HALF = 10;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sclDrv = 1'b1;
    logic sdaDrv = 1'b1;
    logic busSel = 1'b0;
    logic [7:0] txDataA = 8'h00;
    logic [7:0] txDataB = 8'h00;

    wire sclA = busSel ? 1'b1 : sclDrv;
    wire sclB = busSel ? sclDrv : 1'b1;
    wire sdaA;
    wire sdaB;
    pullup (sdaA);
    pullup (sdaB);
    assign sdaA = (!busSel && !sdaDrv) ? 1'b0 : 1'bz;
    assign sdaB = (busSel && !sdaDrv) ? 1'b0 : 1'bz;
    wire sdaObs = busSel ? sdaB : sdaA;

    logic [7:0] rxDataA, rxDataB;
    logic rxValidA, txReqA, addrMatchA, rwA, nackA, busyA;
    logic rxValidB, txReqB, addrMatchB, rwB, nackB, busyB;

    int checks = 0;
    int failures = 0;
    int addrMatchCnt = 0, rxValidCnt = 0, txReqCnt = 0, nackCnt = 0;
    int addrMatchCntB = 0, rxValidCntB = 0, otherCntB = 0;

    logic [7:0] got;
    logic bitGot;

    i2c_target #(.SLAVE_ADDR(7'h50), .FRAME_BITS(8), .SYNC_STAGES(2)) dutA (
        .clk(clk), .rst_n(rst_n), .scl(sclA), .sda(sdaA), .tx_data(txDataA),
        .rx_data(rxDataA), .rx_valid(rxValidA), .tx_req(txReqA), .addr_match(addrMatchA),
        .rw_latched(rwA), .nack_rx(nackA), .busy(busyA)
    );

    i2c_target #(.SLAVE_ADDR(7'h50), .FRAME_BITS(4), .SYNC_STAGES(2)) dutB (
        .clk(clk), .rst_n(rst_n), .scl(sclB), .sda(sdaB), .tx_data(txDataB),
        .rx_data(rxDataB), .rx_valid(rxValidB), .tx_req(txReqB), .addr_match(addrMatchB),
        .rw_latched(rwB), .nack_rx(nackB), .busy(busyB)
    );

    always #5 clk = ~clk;

    // Pulse counters sample on the falling clk edge, away from register updates.
    always @(negedge clk) begin
        if (addrMatchA) addrMatchCnt++;
        if (rxValidA)   rxValidCnt++;
        if (txReqA)     txReqCnt++;
        if (nackA)      nackCnt++;
        if (addrMatchB) addrMatchCntB++;
        if (rxValidB)   rxValidCntB++;
        if (txReqB || nackB) otherCntB++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic sclV, input logic sdaV, input int n);
        sclDrv = sclV;
        sdaDrv = sdaV;
        tick(n);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic startCond();
        applyStimulus(sclDrv, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, HALF);
        applyStimulus(1'b1, 1'b0, HALF);
        applyStimulus(1'b0, 1'b0, 2);
    endtask

    task automatic stopCond();
        applyStimulus(1'b0, 1'b0, HALF);
        applyStimulus(1'b1, 1'b0, HALF);
        applyStimulus(1'b1, 1'b1, HALF);
    endtask

    task automatic writeBit(input logic b);
        applyStimulus(1'b0, b, HALF);
        applyStimulus(1'b1, b, HALF);
        applyStimulus(1'b0, b, 2);
    endtask

    // Reads SDA near both ends of the SCL high phase; X if it moved in between.
    task automatic readBit(output logic b);
        logic s1, s2;
        applyStimulus(1'b0, 1'b1, HALF);
        applyStimulus(1'b1, 1'b1, 1);
        s1 = sdaObs;
        applyStimulus(1'b1, 1'b1, HALF - 2);
        s2 = sdaObs;
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 2);
        b = (s1 === s2) ? s1 : 1'bx;
    endtask

    task automatic writeFrame(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) writeBit(v[i]);
    endtask

    task automatic readFrame(output logic [7:0] v, input int n);
        logic b;
        v = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            readBit(b);
            v[i] = b;
        end
    endtask

    initial begin
        // Power-on reset
        tick(4);
        checkOutput("reset_sda", sdaA, 8'h01);
        checkOutput("reset_busy", busyA, 8'h00);
        checkOutput("reset_rx_data", rxDataA, 8'h00);
        checkOutput("reset_rw", rwA, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // Write 0x50, data 0xA5
        startCond();
        writeFrame(8'hA0, 8);
        readBit(bitGot);
        checkOutput("w1_addr_ack", bitGot, 8'h00);
        checkOutput("w1_addr_match_cnt", 8'(addrMatchCnt), 8'h01);
        checkOutput("w1_busy", busyA, 8'h01);
        checkOutput("w1_rw", rwA, 8'h00);
        writeFrame(8'hA5, 8);
        readBit(bitGot);
        checkOutput("w1_data_ack", bitGot, 8'h00);
        checkOutput("w1_rx_data", rxDataA, 8'hA5);
        checkOutput("w1_rx_valid_cnt", 8'(rxValidCnt), 8'h01);
        applyStimulus(1'b0, 1'b0, HALF);
        applyStimulus(1'b1, 1'b0, HALF);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("w1_busy_after_stop_1clk", busyA, 8'h01);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("w1_busy_after_stop_4clk", busyA, 8'h00);
        applyStimulus(1'b1, 1'b1, HALF);

        // Write to 0x51: no response at all
        startCond();
        writeFrame(8'hA2, 8);
        readBit(bitGot);
        checkOutput("w2_addr_nack", bitGot, 8'h01);
        checkOutput("w2_addr_match_cnt", 8'(addrMatchCnt), 8'h01);
        checkOutput("w2_busy", busyA, 8'h00);
        writeFrame(8'h5A, 8);
        readBit(bitGot);
        checkOutput("w2_data_nack", bitGot, 8'h01);
        checkOutput("w2_rx_valid_cnt", 8'(rxValidCnt), 8'h01);
        stopCond();

        // Read from 0x50: 0x3C ACKed, 0xC3 NACKed
        txDataA = 8'h3C;
        startCond();
        writeFrame(8'hA1, 8);
        readBit(bitGot);
        checkOutput("r1_addr_ack", bitGot, 8'h00);
        checkOutput("r1_tx_req_cnt_addr", 8'(txReqCnt), 8'h01);
        checkOutput("r1_rw", rwA, 8'h01);
        readFrame(got, 8);
        checkOutput("r1_byte1", got, 8'h3C);
        txDataA = 8'hC3;
        writeBit(1'b0);
        checkOutput("r1_tx_req_cnt_ack", 8'(txReqCnt), 8'h02);
        readFrame(got, 8);
        checkOutput("r1_byte2", got, 8'hC3);
        writeBit(1'b1);
        checkOutput("r1_nack_cnt", 8'(nackCnt), 8'h01);
        readBit(bitGot);
        checkOutput("r1_released", bitGot, 8'h01);
        checkOutput("r1_tx_req_cnt_final", 8'(txReqCnt), 8'h02);
        stopCond();
        checkOutput("r1_busy_end", busyA, 8'h00);

        // Partial write, then repeated START into a read
        txDataA = 8'h5A;
        startCond();
        writeFrame(8'hA0, 8);
        readBit(bitGot);
        checkOutput("rs_addr_ack", bitGot, 8'h00);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        checkOutput("rs_busy_mid", busyA, 8'h01);
        startCond();
        checkOutput("rs_busy_restart", busyA, 8'h01);
        writeFrame(8'hA1, 8);
        readBit(bitGot);
        checkOutput("rs_read_ack", bitGot, 8'h00);
        checkOutput("rs_rw", rwA, 8'h01);
        checkOutput("rs_busy_read", busyA, 8'h01);
        checkOutput("rs_rx_valid_cnt", 8'(rxValidCnt), 8'h01);
        checkOutput("rs_addr_match_cnt", 8'(addrMatchCnt), 8'h04);
        readFrame(got, 8);
        checkOutput("rs_byte", got, 8'h5A);
        writeBit(1'b1);
        checkOutput("rs_nack_cnt", 8'(nackCnt), 8'h02);
        stopCond();

        // Reset while the target drives a 0 data bit
        txDataA = 8'h00;
        startCond();
        writeFrame(8'hA1, 8);
        readBit(bitGot);
        checkOutput("rst_addr_ack", bitGot, 8'h00);
        tick(4);
        checkOutput("rst_sda_driven", sdaA, 8'h00);
        rst_n = 1'b0;
        tick(1);
        checkOutput("rst_sda_released", sdaA, 8'h01);
        checkOutput("rst_busy", busyA, 8'h00);
        checkOutput("rst_rw", rwA, 8'h00);
        checkOutput("rst_rx_data", rxDataA, 8'h00);
        checkOutput("rst_pulses", {4'h0, rxValidA, txReqA, addrMatchA, nackA}, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, HALF);
        startCond();
        writeFrame(8'hA0, 8);
        readBit(bitGot);
        checkOutput("post_rst_addr_ack", bitGot, 8'h00);
        writeFrame(8'h3A, 8);
        readBit(bitGot);
        checkOutput("post_rst_data_ack", bitGot, 8'h00);
        stopCond();
        checkOutput("post_rst_rx_data", rxDataA, 8'h3A);
        checkOutput("post_rst_rx_valid_cnt", 8'(rxValidCnt), 8'h02);

        // 4-bit frames on bus B: address 4'b0000, data 4'b1010
        busSel = 1'b1;
        tick(4);
        startCond();
        writeFrame(8'h00, 4);
        readBit(bitGot);
        checkOutput("fb4_addr_ack", bitGot, 8'h00);
        checkOutput("fb4_addr_match_cnt", 8'(addrMatchCntB), 8'h01);
        writeFrame(8'h0A, 4);
        readBit(bitGot);
        checkOutput("fb4_data_ack", bitGot, 8'h00);
        stopCond();
        checkOutput("fb4_rx_data", rxDataB, 8'h0A);
        checkOutput("fb4_rx_valid_cnt", 8'(rxValidCntB), 8'h01);
        checkOutput("fb4_busy_end", busyB, 8'h00);
        checkOutput("fb4_rw", rwB, 8'h00);
        checkOutput("fb4_no_read_pulses", 8'(otherCntB), 8'h00);
        checkOutput("busA_untouched_rx_valid_cnt", 8'(rxValidCnt), 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
